// File: rtl/mips_decls_p.sv
// Shared declarations for the multicycle MIPS controller.
// Holds the opcode/funct field types, the opcode and funct constants, the FSM
// state type, the 2-bit datapath select encodings and the control word struct
// produced by the state decoder.
package mips_decls_p;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_J     = 6'b000010;
  localparam opcode_t OP_JAL   = 6'b000011;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_ADDI  = 6'b001000;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam funct_t  FUNCT_JR = 6'b001000;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    ADDIEX  = 4'd8,
    ADDIWB  = 4'd9,
    BEQEX   = 4'd10,
    JEX     = 4'd11,
    JALEX   = 4'd12,
    JREX    = 4'd13,
    ERROR   = 4'd14
  } statetype_t;

  localparam logic [1:0] PCSRC_SEQ     = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;
  localparam logic [1:0] PCSRC_JR      = 2'b11;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BRT   = 2'b11;

  localparam logic [1:0] REGDST_RT     = 2'b00;
  localparam logic [1:0] REGDST_RD     = 2'b01;
  localparam logic [1:0] REGDST_RA     = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM  = 2'b01;
  localparam logic [1:0] MEMTOREG_PC   = 2'b10;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control decoder for the multicycle controller.
// Ports:
//   state     in  current FSM state
//   zero      in  ALU zero flag (qualifies the branch PC write)
//   mem_ready in  memory completes this cycle (qualifies the fetch IR/PC write)
//   ctrl      out full control word; every field not named for a state is 0
module mc_outdec
  import mips_decls_p::*;
(
  input  statetype_t state,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Map each state to its datapath enables and selects.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = ALUSRCB_FOUR;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
        ctrl.pcsrc   = PCSRC_SEQ;
      end
      DECODE:  ctrl.alusrcb = ALUSRCB_BRT;
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.memread = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = MEMTOREG_MEM;
        ctrl.regdst   = REGDST_RT;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = REGDST_RD;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = REGDST_RT;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_BRANCH;
        ctrl.pcwrite = zero;
      end
      JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      JALEX: begin
        ctrl.pcsrc    = PCSRC_JUMP;
        ctrl.pcwrite  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = REGDST_RA;
        ctrl.memtoreg = MEMTOREG_PC;
      end
      JREX: begin
        ctrl.pcsrc   = PCSRC_JR;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;  // ERROR and unused encodings: everything off
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM (Moore) with memory-wait timeout and sticky
// illegal/timeout flags.
// Parameters:
//   MEM_TIMEOUT  max consecutive memory wait cycles before ERROR (0 = never)
//   EN_LINK      1 enables JAL/JR, 0 decodes them as illegal
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   opcode, funct         instruction fields, looked at only in DECODE
//   zero, mem_ready       ALU zero flag, memory completion strobe
//   pcwrite..alusrca      1-bit datapath enables/selects
//   regdst..pcsrc         2-bit datapath selects
//   state                 current state (debug)
//   illegal, timeout      sticky error flags, cleared only by reset
module mc_controller
  import mips_decls_p::*;
#(
  parameter int unsigned MEM_TIMEOUT = 32'd16,
  parameter int unsigned EN_LINK     = 32'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  opcode_t    opcode,
  input  funct_t     funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output statetype_t state,
  output logic       illegal,
  output logic       timeout
);

  // A zero timeout still needs a legal 1-bit counter.
  localparam int unsigned CW      = (MEM_TIMEOUT > 32'd0) ? $clog2(MEM_TIMEOUT + 32'd1) : 32'd1;
  localparam int unsigned TO_LIM  = (MEM_TIMEOUT > 32'd0) ? (MEM_TIMEOUT - 32'd1) : 32'd0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LIM);
  localparam logic          LINK_ON = (EN_LINK != 32'd0);

  statetype_t    state_r;
  statetype_t    state_next;
  logic [CW-1:0] wait_cnt_r;
  logic          is_sw_r;
  logic          illegal_r;
  logic          timeout_r;
  logic          set_illegal;
  logic          set_timeout;
  logic          in_wait;
  logic          to_hit;
  ctrl_t         ctrl;

  assign in_wait = (state_r == FETCH) || (state_r == MEMRD) || (state_r == MEMWR);
  // The cycle being counted is the one that reaches the limit; mem_ready wins.
  assign to_hit  = (MEM_TIMEOUT > 32'd0) && in_wait && !mem_ready && (wait_cnt_r == TO_LAST);

  // Next-state logic and error-flag set requests.
  always_comb begin
    state_next  = state_r;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_r)
      FETCH, MEMRD, MEMWR: begin
        if (mem_ready) begin
          if (state_r == FETCH) begin
            state_next = DECODE;
          end else if (state_r == MEMRD) begin
            state_next = MEMWB;
          end else begin
            state_next = FETCH;
          end
        end else if (to_hit) begin
          state_next  = ERROR;
          set_timeout = 1'b1;
        end else begin
          state_next = state_r;
        end
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          OP_JAL: begin
            if (LINK_ON) begin
              state_next = JALEX;
            end else begin
              state_next  = ERROR;
              set_illegal = 1'b1;
            end
          end
          OP_RTYPE: begin
            if (funct != FUNCT_JR) begin
              state_next = RTYPEEX;
            end else if (LINK_ON) begin
              state_next = JREX;
            end else begin
              state_next  = ERROR;
              set_illegal = 1'b1;
            end
          end
          default: begin
            state_next  = ERROR;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (is_sw_r) begin
          state_next = MEMWR;
        end else begin
          state_next = MEMRD;
        end
      end
      RTYPEEX: state_next = ALUWB;
      ADDIEX:  state_next = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BEQEX, JEX, JALEX, JREX: state_next = FETCH;
      default: state_next = ERROR;  // ERROR holds until reset
    endcase
  end

  // State register, wait counter, load/store latch and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= FETCH;
      wait_cnt_r <= '0;
      is_sw_r    <= 1'b0;
      illegal_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r   <= state_next;
      illegal_r <= illegal_r | set_illegal;
      timeout_r <= timeout_r | set_timeout;
      if (state_next != state_r) begin
        wait_cnt_r <= '0;
      end else if (in_wait && !mem_ready) begin
        wait_cnt_r <= wait_cnt_r + CW'(1'b1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      // Opcode is only valid in DECODE, so remember load vs store for MEMADR.
      if (state_r == DECODE) begin
        is_sw_r <= (opcode == OP_SW);
      end else begin
        is_sw_r <= is_sw_r;
      end
    end
  end

  mc_outdec u_outdec (
    .state     (state_r),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Write/read strobes are forced off while reset is held.
  assign pcwrite  = ctrl.pcwrite  & ~reset;
  assign irwrite  = ctrl.irwrite  & ~reset;
  assign regwrite = ctrl.regwrite & ~reset;
  assign memread  = ctrl.memread  & ~reset;
  assign memwrite = ctrl.memwrite & ~reset;
  assign iord     = ctrl.iord;
  assign alusrca  = ctrl.alusrca;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsrc    = ctrl.pcsrc;
  assign state    = state_r;
  assign illegal  = illegal_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: a default instance, a
// MEM_TIMEOUT=4 instance and an EN_LINK=0 instance share one stimulus stream.
module tb_mc_controller;
  import mips_decls_p::*;

  logic    clk = 1'b0;
  logic    reset;
  opcode_t opcode;
  funct_t  funct;
  logic    zero;
  logic    mem_ready;

  int checks   = 0;
  int failures = 0;

  logic a_pcwrite, a_irwrite, a_regwrite, a_memread, a_memwrite, a_iord, a_alusrca;
  logic [1:0] a_regdst, a_memtoreg, a_alusrcb, a_aluop, a_pcsrc;
  statetype_t a_state;
  logic a_illegal, a_timeout;

  logic t_pcwrite, t_irwrite, t_regwrite, t_memread, t_memwrite, t_iord, t_alusrca;
  logic [1:0] t_regdst, t_memtoreg, t_alusrcb, t_aluop, t_pcsrc;
  statetype_t t_state;
  logic t_illegal, t_timeout;

  logic n_pcwrite, n_irwrite, n_regwrite, n_memread, n_memwrite, n_iord, n_alusrca;
  logic [1:0] n_regdst, n_memtoreg, n_alusrcb, n_aluop, n_pcsrc;
  statetype_t n_state;
  logic n_illegal, n_timeout;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(a_pcwrite), .irwrite(a_irwrite), .regwrite(a_regwrite), .memread(a_memread),
    .memwrite(a_memwrite), .iord(a_iord), .alusrca(a_alusrca), .regdst(a_regdst),
    .memtoreg(a_memtoreg), .alusrcb(a_alusrcb), .aluop(a_aluop), .pcsrc(a_pcsrc),
    .state(a_state), .illegal(a_illegal), .timeout(a_timeout)
  );

  mc_controller #(.MEM_TIMEOUT(32'd4)) dut_t (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(t_pcwrite), .irwrite(t_irwrite), .regwrite(t_regwrite), .memread(t_memread),
    .memwrite(t_memwrite), .iord(t_iord), .alusrca(t_alusrca), .regdst(t_regdst),
    .memtoreg(t_memtoreg), .alusrcb(t_alusrcb), .aluop(t_aluop), .pcsrc(t_pcsrc),
    .state(t_state), .illegal(t_illegal), .timeout(t_timeout)
  );

  mc_controller #(.EN_LINK(32'd0)) dut_nl (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(n_pcwrite), .irwrite(n_irwrite), .regwrite(n_regwrite), .memread(n_memread),
    .memwrite(n_memwrite), .iord(n_iord), .alusrca(n_alusrca), .regdst(n_regdst),
    .memtoreg(n_memtoreg), .alusrcb(n_alusrcb), .aluop(n_aluop), .pcsrc(n_pcsrc),
    .state(n_state), .illegal(n_illegal), .timeout(n_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = OP_LW; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    // Reset state and gating while reset is high
    chk("rst_state",   32'(a_state), 32'(FETCH));
    chk("rst_pcwrite", 32'(a_pcwrite), 32'd0);
    chk("rst_memread", 32'(a_memread), 32'd0);
    chk("rst_illegal", 32'(a_illegal), 32'd0);
    chk("rst_timeout", 32'(a_timeout), 32'd0);
    reset = 1'b0; #1;
    chk("fetch_memread", 32'(a_memread), 32'd1);
    chk("fetch_irwrite", 32'(a_irwrite), 32'd1);
    chk("fetch_pcwrite", 32'(a_pcwrite), 32'd1);
    chk("fetch_alusrcb", 32'(a_alusrcb), 32'd1);

    // LW, memory always ready
    step(); chk("lw_decode", 32'(a_state), 32'(DECODE));
    chk("lw_dec_alusrcb", 32'(a_alusrcb), 32'd3);
    chk("lw_dec_regwrite", 32'(a_regwrite), 32'd0);
    step(); chk("lw_memadr", 32'(a_state), 32'(MEMADR));
    chk("lw_adr_alusrca", 32'(a_alusrca), 32'd1);
    chk("lw_adr_alusrcb", 32'(a_alusrcb), 32'd2);
    step(); chk("lw_memrd", 32'(a_state), 32'(MEMRD));
    chk("lw_rd_iord", 32'(a_iord), 32'd1);
    chk("lw_rd_memread", 32'(a_memread), 32'd1);
    chk("lw_rd_regwrite", 32'(a_regwrite), 32'd0);
    step(); chk("lw_memwb", 32'(a_state), 32'(MEMWB));
    chk("lw_wb_regwrite", 32'(a_regwrite), 32'd1);
    chk("lw_wb_memtoreg", 32'(a_memtoreg), 32'd1);
    chk("lw_wb_regdst", 32'(a_regdst), 32'd0);
    step(); chk("lw_fetch", 32'(a_state), 32'(FETCH));

    // BEQ taken then not taken
    opcode = OP_BEQ; zero = 1'b1;
    step(); step(); chk("beq1_state", 32'(a_state), 32'(BEQEX));
    chk("beq1_pcwrite", 32'(a_pcwrite), 32'd1);
    chk("beq1_pcsrc", 32'(a_pcsrc), 32'd1);
    chk("beq1_aluop", 32'(a_aluop), 32'd1);
    step(); chk("beq1_fetch", 32'(a_state), 32'(FETCH));
    zero = 1'b0;
    step(); step(); chk("beq0_state", 32'(a_state), 32'(BEQEX));
    chk("beq0_pcwrite", 32'(a_pcwrite), 32'd0);
    chk("beq0_pcsrc", 32'(a_pcsrc), 32'd1);
    step();

    // SW with three not-ready cycles in MEMWR
    opcode = OP_SW;
    step(); step(); chk("sw_memadr", 32'(a_state), 32'(MEMADR));
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_state", 32'(a_state), 32'(MEMWR));
      chk("sw_wait_memwrite", 32'(a_memwrite), 32'd1);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("sw_last_state", 32'(a_state), 32'(MEMWR));
    chk("sw_last_memwrite", 32'(a_memwrite), 32'd1);
    step(); chk("sw_fetch", 32'(a_state), 32'(FETCH));
    chk("sw_fetch_memwrite", 32'(a_memwrite), 32'd0);

    // R-type ALU op
    opcode = OP_RTYPE; funct = 6'b100000;
    step(); step(); chk("rt_state", 32'(a_state), 32'(RTYPEEX));
    chk("rt_aluop", 32'(a_aluop), 32'd2);
    step(); chk("rt_wb_state", 32'(a_state), 32'(ALUWB));
    chk("rt_wb_regdst", 32'(a_regdst), 32'd1);
    chk("rt_wb_regwrite", 32'(a_regwrite), 32'd1);

    // JAL (link enabled vs disabled)
    do_reset();
    opcode = OP_JAL;
    step(); step(); chk("jal_state", 32'(a_state), 32'(JALEX));
    chk("jal_regwrite", 32'(a_regwrite), 32'd1);
    chk("jal_regdst", 32'(a_regdst), 32'd2);
    chk("jal_pcsrc", 32'(a_pcsrc), 32'd2);
    chk("jal_memtoreg", 32'(a_memtoreg), 32'd2);
    chk("jal_pcwrite", 32'(a_pcwrite), 32'd1);
    chk("nl_jal_state", 32'(n_state), 32'(ERROR));
    chk("nl_jal_illegal", 32'(n_illegal), 32'd1);

    // JR (link enabled vs disabled)
    do_reset();
    opcode = OP_RTYPE; funct = FUNCT_JR;
    step(); step(); chk("jr_state", 32'(a_state), 32'(JREX));
    chk("jr_pcsrc", 32'(a_pcsrc), 32'd3);
    chk("jr_pcwrite", 32'(a_pcwrite), 32'd1);
    chk("nl_jr_state", 32'(n_state), 32'(ERROR));

    // Illegal opcode lands in a sticky ERROR
    do_reset();
    opcode = 6'b111111;
    step(); step(); chk("ill_state", 32'(a_state), 32'(ERROR));
    chk("ill_illegal", 32'(a_illegal), 32'd1);
    chk("ill_timeout", 32'(a_timeout), 32'd0);
    chk("ill_memread", 32'(a_memread), 32'd0);
    step(); chk("ill_hold", 32'(a_state), 32'(ERROR));

    // Fetch timeout on the MEM_TIMEOUT=4 instance
    do_reset();
    mem_ready = 1'b0; opcode = OP_LW;
    step(); step(); step();
    chk("to_still_fetch", 32'(t_state), 32'(FETCH));
    chk("to_not_yet", 32'(t_timeout), 32'd0);
    step();
    chk("to_error", 32'(t_state), 32'(ERROR));
    chk("to_flag", 32'(t_timeout), 32'd1);
    chk("to_memread", 32'(t_memread), 32'd0);
    chk("to_default_fetch", 32'(a_state), 32'(FETCH));
    reset = 1'b1;
    step();
    chk("to_rst_state", 32'(t_state), 32'(FETCH));
    chk("to_rst_timeout", 32'(t_timeout), 32'd0);
    chk("to_rst_illegal", 32'(t_illegal), 32'd0);
    reset = 1'b0; #1;

    // Reset asserted mid-instruction in MEMRD
    mem_ready = 1'b1; opcode = OP_LW;
    step(); step(); step();
    chk("mrd_state", 32'(a_state), 32'(MEMRD));
    reset = 1'b1; #1;
    chk("mrd_rst_memread", 32'(a_memread), 32'd0);
    step();
    chk("mrd_rst_fetch", 32'(a_state), 32'(FETCH));
    reset = 1'b0; #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
